// File: rtl/forward_operand_supplier_pkg.sv
// Shared forwarding select encoding, used by the forwarding unit
// and by the operand supplier datapath.
package forward_operand_supplier_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXE     = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;
  localparam logic [1:0] FWD_WB      = 2'd3;

  typedef logic [1:0] fwd_sel_t;

  function automatic logic is_exe_sel(input fwd_sel_t s);
    return s == FWD_EXE;
  endfunction

endpackage

// File: rtl/fwd_src_mux4.sv
// 4:1 operand source mux keyed by a forwarding select code.
// Code 0 passes the regfile read data through.
module fwd_src_mux4
  import forward_operand_supplier_pkg::*;
#(
  parameter int W = 32
) (
  input  fwd_sel_t       i_sel,
  input  logic [W-1:0]   i_reg,
  input  logic [W-1:0]   i_exe,
  input  logic [W-1:0]   i_mem,
  input  logic [W-1:0]   i_wb,
  output logic [W-1:0]   o_data
);

  always_comb begin
    o_data = i_reg;
    unique case (1'b1)
      (i_sel == FWD_EXE): o_data = i_exe;
      (i_sel == FWD_MEM): o_data = i_mem;
      (i_sel == FWD_WB):  o_data = i_wb;
      default:            o_data = i_reg;
    endcase
  end

endmodule

// File: rtl/forward_operand_supplier.sv
// Operand forwarding datapath: source muxes, ID/EXE operand latch,
// store-data delay to MEM, load-use bubble insertion and counting.
module forward_operand_supplier
  import forward_operand_supplier_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  fwd_sel_t              EXE_A_Select,
  input  fwd_sel_t              EXE_B_Select,
  input  fwd_sel_t              MEM_Data_select,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] ID_RegA_Data,
  input  logic [DATA_WIDTH-1:0] ID_RegB_Data,
  input  logic [DATA_WIDTH-1:0] EXE_Result,
  input  logic                  EXE_Result_Valid,
  input  logic [DATA_WIDTH-1:0] MEM_Result,
  input  logic [DATA_WIDTH-1:0] WB_Result,
  output logic                  load_use_stall,
  output logic [DATA_WIDTH-1:0] Alt_RegA,
  output logic [DATA_WIDTH-1:0] Alt_RegB,
  output logic [DATA_WIDTH-1:0] Alt_EXE_Store,
  output logic [DATA_WIDTH-1:0] Alt_MEM_Data,
  output logic                  Operand_Valid,
  output logic                  MEM_Store_Valid,
  output logic [CNT_WIDTH-1:0]  bubble_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_st;
  logic                  w_hazard;
  logic                  w_bubble;

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_st;
  logic [DATA_WIDTH-1:0] r_md;
  logic                  r_ov;
  logic                  r_sv;
  logic [CNT_WIDTH-1:0]  r_cnt;

  fwd_src_mux4 #(.W(DATA_WIDTH)) u_mux_a (
    .i_sel  (EXE_A_Select),
    .i_reg  (ID_RegA_Data),
    .i_exe  (EXE_Result),
    .i_mem  (MEM_Result),
    .i_wb   (WB_Result),
    .o_data (w_a)
  );

  fwd_src_mux4 #(.W(DATA_WIDTH)) u_mux_b (
    .i_sel  (EXE_B_Select),
    .i_reg  (ID_RegB_Data),
    .i_exe  (EXE_Result),
    .i_mem  (MEM_Result),
    .i_wb   (WB_Result),
    .o_data (w_b)
  );

  fwd_src_mux4 #(.W(DATA_WIDTH)) u_mux_st (
    .i_sel  (MEM_Data_select),
    .i_reg  (ID_RegB_Data),
    .i_exe  (EXE_Result),
    .i_mem  (MEM_Result),
    .i_wb   (WB_Result),
    .o_data (w_st)
  );

  // A load in EXE has no data yet; anyone forwarding from EXE must wait.
  assign w_hazard = (is_exe_sel(EXE_A_Select) |
                     is_exe_sel(EXE_B_Select) |
                     is_exe_sel(MEM_Data_select)) &
                    ~EXE_Result_Valid;
  assign w_bubble = stall | w_hazard;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_a  <= '0;
      r_b  <= '0;
      r_st <= '0;
      r_ov <= 1'b0;
    end else if (!w_bubble) begin
      r_a  <= w_a;
      r_b  <= w_b;
      r_st <= w_st;
      r_ov <= 1'b1;
    end else begin
      r_ov <= 1'b0;
      if (ZERO_BUBBLE) begin
        r_a  <= '0;
        r_b  <= '0;
        r_st <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_md <= '0;
      r_sv <= 1'b0;
    end else begin
      r_md <= r_st;
      r_sv <= r_ov;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (w_bubble && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign load_use_stall  = w_hazard;
  assign Alt_RegA        = r_a;
  assign Alt_RegB        = r_b;
  assign Alt_EXE_Store   = r_st;
  assign Alt_MEM_Data    = r_md;
  assign Operand_Valid   = r_ov;
  assign MEM_Store_Valid = r_sv;
  assign bubble_count    = r_cnt;

endmodule

// File: tb/tb_forward_operand_supplier.sv
// Self-checking bench: directed scenarios plus random traffic
// against a cycle-level reference model of the operand supplier.
module tb_forward_operand_supplier;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  a_sel, b_sel, s_sel;
  logic        stall, valid;
  logic [31:0] rega, regb, exe, mem, wb;

  logic        lus1, ov1, sv1;
  logic [31:0] a1, b1, st1, md1;
  logic [15:0] bc1;
  logic        lus2, ov2, sv2;
  logic [31:0] a2, b2, st2, md2;
  logic [1:0]  bc2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a, b, st, md;
    logic        ov, sv;
    int          cnt;
  } mstate_t;

  mstate_t m1, m2;

  always #5 CLK = ~CLK;

  forward_operand_supplier dut1 (
    .CLK(CLK), .RESET(RESET),
    .EXE_A_Select(a_sel), .EXE_B_Select(b_sel),
    .MEM_Data_select(s_sel), .stall(stall),
    .ID_RegA_Data(rega), .ID_RegB_Data(regb),
    .EXE_Result(exe), .EXE_Result_Valid(valid),
    .MEM_Result(mem), .WB_Result(wb),
    .load_use_stall(lus1), .Alt_RegA(a1), .Alt_RegB(b1),
    .Alt_EXE_Store(st1), .Alt_MEM_Data(md1),
    .Operand_Valid(ov1), .MEM_Store_Valid(sv1),
    .bubble_count(bc1)
  );

  forward_operand_supplier #(
    .DATA_WIDTH(32), .CNT_WIDTH(2), .ZERO_BUBBLE(1'b0)
  ) dut2 (
    .CLK(CLK), .RESET(RESET),
    .EXE_A_Select(a_sel), .EXE_B_Select(b_sel),
    .MEM_Data_select(s_sel), .stall(stall),
    .ID_RegA_Data(rega), .ID_RegB_Data(regb),
    .EXE_Result(exe), .EXE_Result_Valid(valid),
    .MEM_Result(mem), .WB_Result(wb),
    .load_use_stall(lus2), .Alt_RegA(a2), .Alt_RegB(b2),
    .Alt_EXE_Store(st2), .Alt_MEM_Data(md2),
    .Operand_Valid(ov2), .MEM_Store_Valid(sv2),
    .bubble_count(bc2)
  );

  function automatic logic [31:0] src(input logic [1:0] sel,
                                      input logic [31:0] regv);
    logic [31:0] s [4];
    s[0] = regv; s[1] = exe; s[2] = mem; s[3] = wb;
    return s[sel];
  endfunction

  function automatic logic hz();
    return (a_sel == 2'd1 || b_sel == 2'd1 || s_sel == 2'd1)
           && !valid;
  endfunction

  function automatic mstate_t step(input mstate_t s, input bit z,
                                   input int cap);
    mstate_t n;
    n = s;
    n.md = s.st;
    n.sv = s.ov;
    if (!(stall || hz())) begin
      n.a  = src(a_sel, rega);
      n.b  = src(b_sel, regb);
      n.st = src(s_sel, regb);
      n.ov = 1'b1;
    end else begin
      n.ov = 1'b0;
      if (z) begin n.a = 0; n.b = 0; n.st = 0; end
      if (s.cnt < cap) n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  function automatic mstate_t zero_state();
    mstate_t z;
    z.a = 0; z.b = 0; z.st = 0; z.md = 0;
    z.ov = 0; z.sv = 0; z.cnt = 0;
    return z;
  endfunction

  task automatic tick();
    mstate_t n1, n2;
    n1 = step(m1, 1'b1, 65535);
    n2 = step(m2, 1'b0, 3);
    @(posedge CLK);
    #1;
    if (!RESET) begin
      m1 = zero_state();
      m2 = zero_state();
    end else begin
      m1 = n1;
      m2 = n2;
    end
  endtask

  task automatic idle_inputs();
    a_sel = 0; b_sel = 0; s_sel = 0; stall = 0; valid = 1;
    rega = 0; regb = 0; exe = 0; mem = 0; wb = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    m1 = zero_state();
    m2 = zero_state();
    for (int i = 0; i < 3; i++) begin
      a_sel = 2'($urandom); b_sel = 2'($urandom);
      s_sel = 2'($urandom); stall = 1'($urandom);
      valid = 1'($urandom);
      rega = $urandom; regb = $urandom; exe = $urandom;
      mem = $urandom; wb = $urandom;
      tick();
    end
    checks++;
    if ({a1, b1, st1, md1, ov1, sv1, bc1} !== '0) begin
      errors++;
      $display("FAIL reset_regs got a=%h b=%h st=%h md=%h ov=%b sv=%b cnt=%0d want all 0",
               a1, b1, st1, md1, ov1, sv1, bc1);
    end
    checks++;
    if (bc2 !== 2'd0 || ov2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut2 got cnt=%0d ov=%b want 0 0", bc2, ov2);
    end
    RESET = 1'b1;
    idle_inputs();
    rega = 5; regb = 7;
    tick();
    checks++;
    if (a1 !== 32'd5 || b1 !== 32'd7 || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL first_capture got a=%0d b=%0d ov=%b want 5 7 1",
               a1, b1, ov1);
    end
  endtask

  task automatic test_forward();
    logic [31:0] want;
    idle_inputs();
    exe = 32'h11; mem = 32'h22; wb = 32'h33;
    for (int i = 1; i <= 3; i++) begin
      a_sel = 2'(i);
      want = (i == 1) ? 32'h11 : (i == 2) ? 32'h22 : 32'h33;
      tick();
      checks++;
      if (a1 !== want || ov1 !== 1'b1) begin
        errors++;
        $display("FAIL fwd_sel%0d got a=%h ov=%b want %h 1",
                 i, a1, ov1, want);
      end
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    b_sel = 2'd1; valid = 1'b0;
    #1;
    checks++;
    if (lus1 !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b want 1", lus1);
    end
    tick();
    checks++;
    if (ov1 !== 1'b0 || bc1 !== 16'd1 || b1 !== 32'd0) begin
      errors++;
      $display("FAIL lu_bubble got ov=%b cnt=%0d b=%h want 0 1 0",
               ov1, bc1, b1);
    end
    b_sel = 2'd2; mem = 32'hAB; valid = 1'b1;
    #1;
    checks++;
    if (lus1 !== 1'b0) begin
      errors++;
      $display("FAIL lu_resolve got stall=%b want 0", lus1);
    end
    tick();
    checks++;
    if (b1 !== 32'hAB || ov1 !== 1'b1 || bc1 !== 16'd1) begin
      errors++;
      $display("FAIL lu_capture got b=%h ov=%b cnt=%0d want ab 1 1",
               b1, ov1, bc1);
    end
  endtask

  task automatic test_store();
    idle_inputs();
    rega = 32'h1; regb = 32'h2;
    s_sel = 2'd3; wb = 32'hDEAD;
    tick();
    checks++;
    if (st1 !== 32'hDEAD) begin
      errors++;
      $display("FAIL store_exe got %h want dead", st1);
    end
    tick();
    checks++;
    if (md1 !== 32'hDEAD || sv1 !== 1'b1) begin
      errors++;
      $display("FAIL store_mem got md=%h sv=%b want dead 1", md1, sv1);
    end
  endtask

  task automatic test_simultaneous();
    stall = 1'b1; a_sel = 2'd1; valid = 1'b0;
    tick();
    checks++;
    if (bc1 !== 16'd2 || ov1 !== 1'b0 || bc2 !== 2'd2) begin
      errors++;
      $display("FAIL simul got cnt1=%0d ov=%b cnt2=%0d want 2 0 2",
               bc1, ov1, bc2);
    end
    a_sel = 2'd0; valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bc2 !== 2'd3) begin
      errors++;
      $display("FAIL saturate got %0d want 3", bc2);
    end
    checks++;
    if (bc1 !== 16'd7) begin
      errors++;
      $display("FAIL count16 got %0d want 7", bc1);
    end
    checks++;
    if (b2 !== 32'h2 || b1 !== 32'h0 || ov2 !== 1'b0) begin
      errors++;
      $display("FAIL bubble_regs got b2=%h b1=%h ov2=%b want 2 0 0",
               b2, b1, ov2);
    end
    stall = 1'b0;
  endtask

  task automatic test_async_reset();
    idle_inputs();
    rega = 32'h55; regb = 32'h66; s_sel = 2'd2; mem = 32'h77;
    tick();
    tick();
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if ({a1, b1, st1, md1, ov1, sv1, bc1} !== '0 || bc2 !== 2'd0) begin
      errors++;
      $display("FAIL async_rst got a=%h b=%h st=%h md=%h ov=%b cnt=%0d want all 0",
               a1, b1, st1, md1, ov1, bc1);
    end
    m1 = zero_state();
    m2 = zero_state();
    RESET = 1'b1;
    idle_inputs();
    rega = 32'h99;
    tick();
    checks++;
    if (a1 !== 32'h99 || ov1 !== 1'b1 || bc1 !== 16'd0) begin
      errors++;
      $display("FAIL post_rst got a=%h ov=%b cnt=%0d want 99 1 0",
               a1, ov1, bc1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      a_sel = 2'($urandom); b_sel = 2'($urandom);
      s_sel = 2'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      valid = ($urandom_range(0, 3) != 0);
      rega = $urandom; regb = $urandom; exe = $urandom;
      mem = $urandom; wb = $urandom;
      #1;
      checks++;
      if (lus1 !== hz() || lus2 !== hz()) begin
        errors++;
        $display("FAIL rnd%0d_lus got %b/%b want %b",
                 i, lus1, lus2, hz());
      end
      tick();
      checks++;
      if (a1 !== m1.a || b1 !== m1.b || st1 !== m1.st ||
          md1 !== m1.md || ov1 !== m1.ov || sv1 !== m1.sv ||
          bc1 !== 16'(m1.cnt)) begin
        errors++;
        $display("FAIL rnd%0d_dut1 got a=%h b=%h st=%h md=%h ov=%b sv=%b cnt=%0d want %h %h %h %h %b %b %0d",
                 i, a1, b1, st1, md1, ov1, sv1, bc1,
                 m1.a, m1.b, m1.st, m1.md, m1.ov, m1.sv, m1.cnt);
      end
      checks++;
      if (a2 !== m2.a || b2 !== m2.b || st2 !== m2.st ||
          md2 !== m2.md || ov2 !== m2.ov || sv2 !== m2.sv ||
          bc2 !== 2'(m2.cnt)) begin
        errors++;
        $display("FAIL rnd%0d_dut2 got a=%h b=%h st=%h md=%h ov=%b sv=%b cnt=%0d want %h %h %h %h %b %b %0d",
                 i, a2, b2, st2, md2, ov2, sv2, bc2,
                 m2.a, m2.b, m2.st, m2.md, m2.ov, m2.sv, m2.cnt);
      end
    end
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_store();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
